// File: rtl/punc_controller.sv
// Multi-cycle fetch/decode/execute control FSM for the PUnC LC3 datapath.
// Outputs are decoded combinationally from the current state and IR.
module punc_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir_to_controller,
  input  logic        nzp_true,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic [1:0]  pc_sel,
  output logic        ir_ld,
  output logic        ir_clr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  mem_r_addr_sel,
  output logic [1:0]  mem_w_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_w_addr_sel,
  output logic        rf_w_wr,
  output logic        rf_r0_addr_sel,
  output logic        rf_r0_rd,
  output logic        rf_r1_rd,
  output logic        prev_ld,
  output logic        nzp_ld,
  output logic        nzp_clr,
  output logic [1:0]  alu_sel,
  output logic        alu_first_val_sel,
  output logic        halted
);

  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                         OP_ST  = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                         OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
                         OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                         OP_LEA = 4'b1110, OP_HLT = 4'b1111;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, EXEC2, HALT} state_t;

  state_t      state;
  logic [3:0]  opcode;
  logic        unused_ir_bits;

  assign opcode = ir_to_controller[15:12];
  // Register fields are consumed by the datapath directly, not here.
  assign unused_ir_bits = ^{ir_to_controller[10:6], ir_to_controller[4:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   state <= DECODE;
        DECODE:  state <= (opcode == OP_HLT) ? HALT : EXEC;
        EXEC:    state <= (opcode == OP_LDI || opcode == OP_STI) ? EXEC2 : FETCH;
        EXEC2:   state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_ld = 1'b0;  pc_clr = 1'b0;  pc_inc = 1'b0;  pc_sel = 2'd0;
    ir_ld = 1'b0;  ir_clr = 1'b0;  mem_rd = 1'b0;  mem_wr = 1'b0;
    mem_r_addr_sel = 2'd0;  mem_w_addr_sel = 2'd0;  rf_w_data_sel = 2'd0;
    rf_w_addr_sel = 1'b0;  rf_w_wr = 1'b0;  rf_r0_addr_sel = 1'b0;
    rf_r0_rd = 1'b0;  rf_r1_rd = 1'b0;  prev_ld = 1'b0;  nzp_ld = 1'b0;
    nzp_clr = 1'b0;  alu_sel = 2'd0;  alu_first_val_sel = 1'b0;  halted = 1'b0;

    if (rst) begin
      pc_clr  = 1'b1;
      ir_clr  = 1'b1;
      nzp_clr = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          mem_rd = 1'b1;
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
        end
        EXEC: begin
          case (opcode)
            OP_ADD, OP_AND: begin
              rf_r1_rd = 1'b1;
              alu_sel  = (opcode == OP_ADD) ? 2'd1 : 2'd2;
              if (ir_to_controller[5]) begin
                alu_first_val_sel = 1'b1;
              end else begin
                rf_r0_addr_sel = 1'b1;
                rf_r0_rd       = 1'b1;
              end
              rf_w_wr       = 1'b1;
              rf_w_addr_sel = 1'b1;
              nzp_ld        = 1'b1;
            end
            OP_NOT: begin
              alu_sel       = 2'd3;
              rf_r1_rd      = 1'b1;
              rf_w_wr       = 1'b1;
              rf_w_addr_sel = 1'b1;
              nzp_ld        = 1'b1;
            end
            OP_BR: begin
              pc_ld = nzp_true;
            end
            OP_JMP: begin
              rf_r1_rd = 1'b1;
              pc_ld    = 1'b1;
              pc_sel   = 2'd2;
            end
            // Link write and PC load share an edge, so R7 captures the old PC.
            OP_JSR: begin
              rf_w_wr       = 1'b1;
              rf_w_data_sel = 2'd3;
              pc_ld         = 1'b1;
              if (ir_to_controller[11]) begin
                pc_sel = 2'd1;
              end else begin
                pc_sel   = 2'd2;
                rf_r1_rd = 1'b1;
              end
            end
            OP_LD, OP_LDR: begin
              mem_rd         = 1'b1;
              mem_r_addr_sel = (opcode == OP_LDR) ? 2'd3 : 2'd1;
              rf_r1_rd       = (opcode == OP_LDR);
              rf_w_wr        = 1'b1;
              rf_w_addr_sel  = 1'b1;
              rf_w_data_sel  = 2'd2;
              nzp_ld         = 1'b1;
            end
            OP_LEA: begin
              rf_w_wr       = 1'b1;
              rf_w_addr_sel = 1'b1;
              rf_w_data_sel = 2'd1;
              nzp_ld        = 1'b1;
            end
            OP_ST, OP_STR: begin
              mem_wr         = 1'b1;
              mem_w_addr_sel = (opcode == OP_STR) ? 2'd2 : 2'd0;
              rf_r0_rd       = 1'b1;
              rf_r1_rd       = (opcode == OP_STR);
            end
            // Pointer fetch lands in DR; it is overwritten by the real data next cycle.
            OP_LDI: begin
              mem_rd         = 1'b1;
              mem_r_addr_sel = 2'd1;
              rf_w_wr        = 1'b1;
              rf_w_addr_sel  = 1'b1;
              rf_w_data_sel  = 2'd2;
            end
            OP_STI: begin
              mem_rd         = 1'b1;
              mem_r_addr_sel = 2'd1;
              prev_ld        = 1'b1;
            end
            default: begin
            end
          endcase
        end
        EXEC2: begin
          if (opcode == OP_LDI) begin
            mem_rd         = 1'b1;
            mem_r_addr_sel = 2'd2;
            rf_r0_rd       = 1'b1;
            rf_w_wr        = 1'b1;
            rf_w_addr_sel  = 1'b1;
            rf_w_data_sel  = 2'd2;
            nzp_ld         = 1'b1;
          end else if (opcode == OP_STI) begin
            mem_wr         = 1'b1;
            mem_w_addr_sel = 2'd1;
            rf_r0_rd       = 1'b1;
          end
        end
        HALT: begin
          halted = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
